// File: rtl/event_rate_monitor.sv
// ---------------------------------------------------------------------------
// event_rate_monitor
//
// Multi-channel event-rate counter with a Wishbone register interface.
// Each of NUM_CH channels counts single-cycle strobes over a programmable
// gate interval. At the end of every gate all counts are copied atomically
// into result registers, and the next gate starts on the following cycle,
// so no events are lost between gates. Counters saturate at all-ones and set
// a sticky per-channel overflow flag.
//
// Optional feature (macro EVENT_RATE_MONITOR_EXT_PPS_EN):
//   adds input pps_i. With CTRL.ext_gate set, enable arms the monitor and
//   the gate is delimited by pps_i pulses instead of the GATE register.
//   Without the macro, CTRL.ext_gate reads 0 and writes to it are ignored.
//
// Ports:
//   wb_clk_i   sole clock
//   wb_rst_i   asynchronous active-high reset
//   event_i    per-channel event strobes (already synchronous to wb_clk_i)
//   pps_i      external gate pulse (only with EVENT_RATE_MONITOR_EXT_PPS_EN)
//   wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i   Wishbone request
//   wb_dat_o   read data, valid while wb_ack_o is high
//   wb_ack_o   single-cycle acknowledge
//   done_o     one-cycle pulse on the cycle after results are updated
//
// Register map (word address):
//   0 CTRL   [0] enable [1] oneshot [2] clear (write-only pulse)
//            [3] busy (read-only) [4] ext_gate
//   1 GATE   gate length in clock cycles (0 behaves as 1)
//   2 STATUS [15:0] seq, [16+n] sticky overflow of channel n
//   3 reserved (reads 0)
//   4+n      RESULT n, zero-extended to 32 bits
// ---------------------------------------------------------------------------
module event_rate_monitor #(
    parameter int NUM_CH       = 4,
    parameter int CNT_WIDTH    = 32,
    parameter int GATE_DEFAULT = 100000000,
    parameter int ADR_WIDTH    = 6
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NUM_CH-1:0]    event_i,
`ifdef EVENT_RATE_MONITOR_EXT_PPS_EN
    input  logic                 pps_i,
`endif
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [ADR_WIDTH-1:0] wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 done_o
);

    // FSM encoding; ARM is only reachable when external gating is built in
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_ARM  = 2'd2;

    localparam logic [ADR_WIDTH-1:0] ADR_CTRL   = ADR_WIDTH'(32'd0);
    localparam logic [ADR_WIDTH-1:0] ADR_GATE   = ADR_WIDTH'(32'd1);
    localparam logic [ADR_WIDTH-1:0] ADR_STATUS = ADR_WIDTH'(32'd2);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    // Saturating increment: adds the event bit unless already at all-ones
    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] value,
        input logic                 ev
    );
        if (ev && (value != CNT_MAX)) begin
            return value + CNT_WIDTH'(1'b1);
        end else begin
            return value;
        end
    endfunction

    // Architectural state
    logic [1:0]           state_r;
    logic                 enable_r;
    logic                 oneshot_r;
    logic [31:0]          gate_r;
    logic [31:0]          gate_cnt_r;
    logic [15:0]          seq_r;
    logic [NUM_CH-1:0]    ovf_r;
    logic [CNT_WIDTH-1:0] cnt_r [NUM_CH];
    logic [CNT_WIDTH-1:0] res_r [NUM_CH];
    logic                 ack_r;
    logic [31:0]          dat_r;
    logic                 done_r;

    // Decoded control
    logic                 req_s;
    logic                 rd_s;
    logic                 wr_ctrl_s;
    logic                 wr_gate_s;
    logic                 clear_s;
    logic                 abort_s;
    logic                 run_s;
    logic                 busy_s;
    logic                 term_s;
    logic                 latch_s;
    logic                 start_s;
    logic                 arm_fire_s;
    logic                 restart_s;
    logic                 count_s;
    logic [31:0]          gate_load_s;
    logic [NUM_CH-1:0]    ovf_hit_s;
    logic [31:0]          status_s;
    logic [31:0]          rd_data_s;
    logic                 ext_gate_s;
    logic                 pps_s;

`ifdef EVENT_RATE_MONITOR_EXT_PPS_EN
    logic                 ext_gate_r;

    // External gate mode bit, only present when the pps input exists
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ext_gate_r <= 1'b0;
        end else if (wr_ctrl_s) begin
            ext_gate_r <= wb_dat_i[4];
        end else begin
            ext_gate_r <= ext_gate_r;
        end
    end

    assign ext_gate_s = ext_gate_r;
    assign pps_s      = pps_i;
`else
    assign ext_gate_s = 1'b0;
    assign pps_s      = 1'b0;
`endif

    // Bus decode and gate sequencing qualifiers
    always_comb begin
        req_s       = wb_cyc_i & wb_stb_i & ~ack_r;
        rd_s        = req_s & ~wb_we_i;
        wr_ctrl_s   = req_s & wb_we_i & (wb_adr_i == ADR_CTRL);
        wr_gate_s   = req_s & wb_we_i & (wb_adr_i == ADR_GATE);
        clear_s     = wr_ctrl_s & wb_dat_i[2];
        // Writing enable=0 stops any gate in progress without latching
        abort_s     = wr_ctrl_s & ~wb_dat_i[0];
        run_s       = (state_r == ST_RUN);
        busy_s      = run_s | (state_r == ST_ARM);
        // In external mode the pulse ends the gate; otherwise the down-counter
        term_s      = run_s & (ext_gate_s ? pps_s : (gate_cnt_r == 32'd0));
        // A clear on the terminal cycle wins: nothing is latched
        latch_s     = term_s & ~abort_s & ~clear_s;
        start_s     = (state_r == ST_IDLE) & enable_r & ~abort_s;
        arm_fire_s  = (state_r == ST_ARM) & pps_s & ~abort_s;
        restart_s   = (start_s & ~ext_gate_s) | arm_fire_s | (run_s & clear_s) | latch_s;
        count_s     = run_s & ~abort_s & ~restart_s;
        // GATE=0 behaves as a one-cycle gate
        gate_load_s = (gate_r == 32'd0) ? 32'd0 : (gate_r - 32'd1);
        status_s    = {16'(ovf_r), seq_r};
    end

    // Per-channel overflow detection: an event arriving while already saturated
    always_comb begin
        ovf_hit_s = {NUM_CH{1'b0}};
        for (int n = 0; n < NUM_CH; n++) begin
            ovf_hit_s[n] = event_i[n] & (cnt_r[n] == CNT_MAX);
        end
    end

    // Read multiplexer; samples current register values before any update
    always_comb begin
        rd_data_s = 32'd0;
        case (wb_adr_i)
            ADR_CTRL:   rd_data_s = {27'd0, ext_gate_s, busy_s, 1'b0, oneshot_r, enable_r};
            ADR_GATE:   rd_data_s = gate_r;
            ADR_STATUS: rd_data_s = status_s;
            default: begin
                // Word 3 and any address beyond the last result read as 0
                for (int n = 0; n < NUM_CH; n++) begin
                    if (wb_adr_i == ADR_WIDTH'(32'd4 + 32'(n))) begin
                        rd_data_s = 32'(res_r[n]);
                    end else begin
                        rd_data_s = rd_data_s;
                    end
                end
            end
        endcase
    end

    // Wishbone handshake, read data and done pulse
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_r  <= 1'b0;
            dat_r  <= 32'd0;
            done_r <= 1'b0;
        end else begin
            ack_r  <= req_s;
            dat_r  <= rd_s ? rd_data_s : 32'd0;
            done_r <= latch_s;
        end
    end

    // Control registers: enable, oneshot, gate length and sequence number
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            enable_r  <= 1'b0;
            oneshot_r <= 1'b0;
            gate_r    <= 32'(GATE_DEFAULT);
            seq_r     <= 16'd0;
        end else begin
            // A one-shot gate that completes drops enable, overriding any write
            if (latch_s && oneshot_r) begin
                enable_r <= 1'b0;
            end else if (wr_ctrl_s) begin
                enable_r <= wb_dat_i[0];
            end else begin
                enable_r <= enable_r;
            end

            if (wr_ctrl_s) begin
                oneshot_r <= wb_dat_i[1];
            end else begin
                oneshot_r <= oneshot_r;
            end

            // New gate length is picked up only at the next reload
            if (wr_gate_s) begin
                gate_r <= wb_dat_i;
            end else begin
                gate_r <= gate_r;
            end

            if (clear_s) begin
                seq_r <= 16'd0;
            end else if (latch_s) begin
                seq_r <= seq_r + 16'd1;
            end else begin
                seq_r <= seq_r;
            end
        end
    end

    // Gate FSM and gate down-counter
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r    <= ST_IDLE;
            gate_cnt_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r    <= ext_gate_s ? ST_ARM : ST_RUN;
                        gate_cnt_r <= gate_load_s;
                    end else begin
                        state_r    <= ST_IDLE;
                        gate_cnt_r <= gate_cnt_r;
                    end
                end
                ST_ARM: begin
                    if (abort_s) begin
                        state_r    <= ST_IDLE;
                        gate_cnt_r <= gate_cnt_r;
                    end else if (pps_s) begin
                        state_r    <= ST_RUN;
                        gate_cnt_r <= gate_load_s;
                    end else begin
                        state_r    <= ST_ARM;
                        gate_cnt_r <= gate_cnt_r;
                    end
                end
                ST_RUN: begin
                    if (abort_s) begin
                        state_r    <= ST_IDLE;
                        gate_cnt_r <= gate_cnt_r;
                    end else if (clear_s || latch_s) begin
                        // Clear restarts the gate; a normal end reloads it
                        state_r    <= (latch_s && oneshot_r) ? ST_IDLE : ST_RUN;
                        gate_cnt_r <= gate_load_s;
                    end else if (gate_cnt_r != 32'd0) begin
                        state_r    <= ST_RUN;
                        gate_cnt_r <= gate_cnt_r - 32'd1;
                    end else begin
                        // Only reached in external mode while waiting for pps
                        state_r    <= ST_RUN;
                        gate_cnt_r <= gate_cnt_r;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    gate_cnt_r <= 32'd0;
                end
            endcase
        end
    end

    // Channel counters, result registers and sticky overflow flags
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int n = 0; n < NUM_CH; n++) begin
                cnt_r[n] <= CNT_ZERO;
                res_r[n] <= CNT_ZERO;
            end
            ovf_r <= {NUM_CH{1'b0}};
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (restart_s) begin
                    cnt_r[n] <= CNT_ZERO;
                end else if (count_s) begin
                    cnt_r[n] <= sat_inc(cnt_r[n], event_i[n]);
                end else begin
                    cnt_r[n] <= cnt_r[n];
                end

                // The terminal-cycle event is folded into the latched result
                if (clear_s) begin
                    res_r[n] <= CNT_ZERO;
                end else if (latch_s) begin
                    res_r[n] <= sat_inc(cnt_r[n], event_i[n]);
                end else begin
                    res_r[n] <= res_r[n];
                end
            end

            if (clear_s) begin
                ovf_r <= {NUM_CH{1'b0}};
            end else if (count_s || latch_s) begin
                ovf_r <= ovf_r | ovf_hit_s;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign wb_ack_o = ack_r;
    assign wb_dat_o = dat_r;
    assign done_o   = done_r;

endmodule

// File: tb/tb_event_rate_monitor.sv
// ---------------------------------------------------------------------------
// Self-checking bench for event_rate_monitor (NUM_CH=4, CNT_WIDTH=8,
// GATE_DEFAULT=100). Register reads push their expected value into a
// scoreboard queue; the value is popped and compared when the acknowledge
// arrives. A monitor counts done_o pulses and checks their spacing.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_event_rate_monitor;

    localparam int NUM_CH       = 4;
    localparam int CNT_WIDTH    = 8;
    localparam int GATE_DEFAULT = 100;
    localparam int ADR_WIDTH    = 6;

    logic                 clk;
    logic                 rst;
    logic [NUM_CH-1:0]    event_i;
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [ADR_WIDTH-1:0] adr;
    logic [31:0]          dat_w;
    logic [31:0]          dat_r;
    logic                 ack;
    logic                 done;
`ifdef EVENT_RATE_MONITOR_EXT_PPS_EN
    logic                 pps;
    int                   pps_period = 0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    int checks     = 0;
    int failures   = 0;
    int ev_mode    = 0;
    int ph         = 0;
    int done_count = 0;
    int cyc_n      = 0;
    int last_done  = -1;
    int gap_exp    = 0;
    int n0;

    event_rate_monitor #(
        .NUM_CH       (NUM_CH),
        .CNT_WIDTH    (CNT_WIDTH),
        .GATE_DEFAULT (GATE_DEFAULT),
        .ADR_WIDTH    (ADR_WIDTH)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .event_i  (event_i),
`ifdef EVENT_RATE_MONITOR_EXT_PPS_EN
        .pps_i    (pps),
`endif
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_dat_i (dat_w),
        .wb_dat_o (dat_r),
        .wb_ack_o (ack),
        .done_o   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One Wishbone access; reads pop their expectation when ack arrives
    task automatic wb_access(input logic w, input int a, input int d);
        bit   got;
        exp_t e;
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = w;
        adr   = ADR_WIDTH'(a);
        dat_w = 32'(d);
        got   = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack) got = 1'b1;
        end
        check_value("ack_seen", {31'd0, got}, 32'd1);
        if (!w && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (got) check_value(e.tag, dat_r, e.val);
        end
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        @(posedge clk);
        #1;
        check_value("ack_one_cycle", {31'd0, ack}, 32'd0);
    endtask

    task automatic wb_write(input int a, input int d);
        wb_access(1'b1, a, d);
    endtask

    task automatic wb_read(input int a, input int exp, input string tag);
        exp_t e;
        e.tag = tag;
        e.val = 32'(exp);
        sb_q.push_back(e);
        wb_access(1'b0, a, 0);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int start;
        bit seen;
        start = done_count;
        seen  = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            if (done_count != start) seen = 1'b1;
        end
        #1;
        check_value(tag, {31'd0, seen}, 32'd1);
    endtask

    // Event stimulus: mode 1 = ch0 every cycle + ch1 every 4th, mode 2 = ch2 only
    initial begin
        event_i = 4'b0000;
`ifdef EVENT_RATE_MONITOR_EXT_PPS_EN
        pps = 1'b0;
`endif
        forever begin
            @(posedge clk);
            #1;
            ph++;
            case (ev_mode)
                1:       event_i = {2'b00, (ph % 4 == 0), 1'b1};
                2:       event_i = 4'b0100;
                default: event_i = 4'b0000;
            endcase
`ifdef EVENT_RATE_MONITOR_EXT_PPS_EN
            pps = (pps_period != 0) && (ph % pps_period == 0);
`endif
        end
    end

    // done_o monitor: counts pulses and checks spacing when requested
    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                done_count++;
                if (gap_exp != 0 && last_done >= 0) begin
                    check_value("done_gap", 32'(cyc_n - last_done), 32'(gap_exp));
                end
                last_done = cyc_n;
            end
            cyc_n++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        adr   = '0;
        dat_w = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check_value("rst_ack", {31'd0, ack}, 32'd0);
        check_value("rst_done", {31'd0, done}, 32'd0);
        check_value("rst_dat", dat_r, 32'd0);
        wb_read(1, 100, "rst_gate");
        wb_read(4, 0, "rst_res0");
        wb_read(3, 0, "rsvd");
        wb_read(0, 0, "rst_ctrl");
        wb_read(2, 0, "rst_status");
        wb_write(10, 32'h1234);
        wb_read(10, 0, "unmapped");

        // Continuous mode, GATE=100
        ev_mode   = 1;
        gap_exp   = 100;
        last_done = -1;
        wb_write(1, 100);
        wb_write(0, 1);
        wb_read(0, 32'h9, "ctrl_busy");
        for (int k = 1; k <= 3; k++) begin
            wait_done(150, "cont_done");
            wb_read(4, 100, "cont_r0");
            wb_read(5, 25, "cont_r1");
            wb_read(2, k, "cont_seq");
        end
        gap_exp = 0;
        wb_write(0, 0);

        // Abort mid-gate: no done, results unchanged
        n0 = done_count;
        wb_write(0, 1);
        wait_cycles(30);
        wb_write(0, 0);
        wait_cycles(150);
        check_value("abort_no_done", 32'(done_count), 32'(n0));
        wb_read(4, 100, "abort_r0");
        wb_read(5, 25, "abort_r1");
        wb_read(2, 3, "abort_seq");
        wb_read(0, 0, "abort_ctrl");

        // GATE write mid-gate affects only the next gate
        last_done = -1;
        gap_exp   = 20;
        wb_write(0, 1);
        wait_cycles(30);
        wb_write(1, 20);
        wait_done(150, "g100_done");
        wb_read(4, 100, "gate_cur_r0");
        wb_read(5, 25, "gate_cur_r1");
        wait_done(40, "g20_done");
        wb_read(4, 20, "gate_next_r0");
        wb_read(5, 5, "gate_next_r1");
        gap_exp = 0;
        wb_write(0, 0);

        // Saturation and sticky overflow, then clear
        wb_write(0, 4);
        wb_read(2, 0, "clr_status");
        wb_read(4, 0, "clr_r0");
        wb_write(1, 300);
        wb_write(0, 1);
        wait_done(400, "sat_done");
        wb_read(4, 255, "sat_r0");
        wb_read(5, 75, "sat_r1");
        wb_read(2, 32'h0001_0001, "sat_status");
        wb_write(0, 0);
        wb_read(2, 32'h0001_0001, "ovf_sticky");
        wb_write(0, 4);
        wb_read(2, 0, "ovf_clear");
        wb_read(4, 0, "clr_r0b");

        // One-shot gate
        ev_mode = 2;
        wb_write(1, 50);
        wb_write(0, 3);
        wait_done(100, "os_done");
        wb_read(6, 50, "os_r2");
        wb_read(4, 0, "os_r0");
        wb_read(0, 32'h2, "os_ctrl");
        wb_read(2, 1, "os_seq");
        n0 = done_count;
        wait_cycles(200);
        check_value("os_no_more_done", 32'(done_count), 32'(n0));

`ifdef EVENT_RATE_MONITOR_EXT_PPS_EN
        // External pps gating: first done after the second pulse
        ev_mode    = 1;
        pps_period = 200;
        wb_write(0, 32'h11);
        wait_done(600, "pps_done");
        wb_read(4, 200, "pps_r0");
        wb_read(5, 50, "pps_r1");
        wb_write(0, 0);
        pps_period = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/event_rate_monitor.md
Name: event_rate_monitor

Overview:
- Multi-channel, single-clock event-rate counter with a Wishbone register interface; successor to the one-off PPS-gated clock-frequency counters at top level.
- Counts single-cycle event strobes on NUM_CH channels over a programmable gate interval. Strobes arrive already synchronised to wb_clk_i, e.g. flag_sync outputs from ADC or reference clock domains.
- Latches all channel counts into readable result registers atomically at gate end, with zero dead time between gates.
- Supports continuous and one-shot modes and saturating counters with sticky overflow flags.

Parameters:
NUM_CH, 4, number of event channels (1..16)
CNT_WIDTH, 32, per-channel counter/result width (1..32); results zero-extended to 32 bits on read
GATE_DEFAULT, 100000000, gate length in wb_clk_i cycles after reset
ADR_WIDTH, 6, Wishbone word-address width; must satisfy 2^ADR_WIDTH >= 4+NUM_CH

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  asynchronous, active-high reset
event_i  in  NUM_CH  per-channel event strobes, one count per cycle high
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  write enable
wb_adr_i  in  ADR_WIDTH  word address
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data, valid with ack
wb_ack_o  out  1  single-cycle acknowledge
done_o  out  1  one-cycle pulse when results are updated

Behaviour:
- Reset: the following all go to 0: wb_ack_o, wb_dat_o, done_o, channel counters, results, overflow flags, seq, CTRL. GATE resets to GATE_DEFAULT. State resets to IDLE.
- Register map (word address):
  - 0 CTRL: [0] enable (RW); [1] oneshot (RW); [2] clear (W, self-clearing, reads 0); [3] busy (RO, 1 in RUN/ARM); [4] ext_gate (see optional feature).
  - 1 GATE: 32-bit gate length; value 0 is treated as 1.
  - 2 STATUS: [15:0] seq (wraps at 0xFFFF->0); [16+n] sticky overflow flag for channel n.
  - 3 reserved, reads 0.
  - 4+n RESULT n.
  - Unmapped reads return 0; unmapped writes are ignored.
- Wishbone: wb_ack_o <= cyc&stb&~ack, so ack comes 1 cycle after request and is never asserted on two consecutive cycles. Write takes effect on the ack cycle. Read data is sampled from register values before any same-cycle update, so a read coincident with a latch returns the old result.
- FSM states: IDLE, RUN, ARM (ARM exists only with the optional feature).
  - IDLE -> RUN: cycle after enable is written 1. Gate counter loads GATE-1 and channel counters clear.
  - RUN: each cycle with event_i[n]=1, counter n increments. At all-ones it holds and sets overflow flag n.
  - Terminal cycle (gate counter == 0):
    - RESULT n <= counter n + event_i[n], saturated, so the terminal-cycle event is included.
    - done_o = 1 next cycle; seq increments.
    - Counters restart from 0 and the gate counter reloads from the current GATE value.
  - oneshot=1 at terminal cycle: enable is cleared and state goes to IDLE.
  - enable written 0 in RUN: abort. No latch, no done_o, results unchanged, IDLE next cycle.
- A GATE write during RUN takes effect at the next reload only.
- clear:
  - Zeros results, overflow flags and seq.
  - If in RUN, also zeros counters and restarts the gate.
  - clear together with a terminal cycle: clear wins; no done_o.
- Events in IDLE are ignored.

Optional Feature:
- Macro: EVENT_RATE_MONITOR_EXT_PPS_EN.
- Defined:
  - Adds port pps_i (in, 1), a single-cycle gate pulse synchronous to wb_clk_i.
  - When CTRL[4] ext_gate=1, enable moves IDLE -> ARM. Events are not counted in ARM.
  - First pps_i moves to RUN and counters clear.
  - In RUN, each pps_i acts as the terminal cycle (same latch rules); GATE is ignored.
  - No pps_i ever: stays ARM/RUN indefinitely, counters saturate.
- Undefined: pps_i absent, no ARM state, CTRL[4] reads 0 and writes are ignored.

Test Plan:
- GATE_DEFAULT=100: reset, read addr 1 -> 100; read addr 4 -> 0; read addr 3 -> 0; wb_ack_o exactly one cycle per access.
- Enable continuous, GATE=100; ch0 strobe every cycle, ch1 every 4th -> RESULT0=100, RESULT1=25; done_o every 100 cycles; seq 1,2,3; no gaps in counted events across gates.
- CNT_WIDTH=8, GATE=300, ch0 constant -> RESULT0=255, STATUS[16]=1 until clear written, then STATUS=0 and RESULT0=0.
- oneshot=1, enable=1, GATE=50, ch2 every cycle -> single done_o, RESULT2=50, CTRL reads enable=0 busy=0, no further done_o over 200 cycles.
- GATE=100: write enable=0 at cycle 30 -> no done_o, previous RESULTs unchanged; write GATE=20 mid-gate -> current gate still 100, next gate 20.
- EXT_PPS_EN, ext_gate=1, pps_i every 200 cycles, ch0 every cycle -> first done_o after second pps_i, RESULT0=200.
